// File: rtl/ysyx_24120013_regfile_sb.sv
// GPR file with a per-register outstanding-write scoreboard fed by IDU issue and EXU writeback.
// Optional write-through read bypass is enabled by defining YSYX_24120013_RF_BYPASS_EN.
module ysyx_24120013_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic                  rs1_busy,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  rs2_busy,
  output logic                  pending_any
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] regs_r    [NREG];
  logic [CNT_WIDTH-1:0]  cnt_r     [NREG];
  logic [CNT_WIDTH-1:0]  cnt_nxt_s [NREG];
  logic                  wb_ready_r;
  logic                  wb_hit_s;
  logic                  iss_hit_s;
  logic                  inc_s     [NREG];
  logic                  dec_s     [NREG];

  assign wb_ready = wb_ready_r;
  assign wb_hit_s = wb_valid & wb_ready_r & (wb_addr != ADDR_ZERO);

  // Issue acceptance looks only at the current count, never at a same-cycle writeback.
  always_comb begin
    iss_ready = 1'b1;
    if (iss_addr == ADDR_ZERO) begin
      iss_ready = 1'b1;
    end else begin
      iss_ready = (cnt_r[iss_addr] != CNT_MAX);
    end
  end

  assign iss_hit_s = iss_valid & iss_ready & (iss_addr != ADDR_ZERO);

  // Next count per register: saturating decrement on writeback plus increment on issue.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      inc_s[i]     = iss_hit_s && (iss_addr == ADDR_WIDTH'(i));
      dec_s[i]     = wb_hit_s && (wb_addr == ADDR_WIDTH'(i)) && (cnt_r[i] != CNT_ZERO);
      cnt_nxt_s[i] = cnt_r[i];
      if (inc_s[i] && !dec_s[i]) begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end else if (dec_s[i] && !inc_s[i]) begin
        cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Register array, counters and writeback-ready flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ready_r <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= DATA_ZERO;
        cnt_r[i]  <= CNT_ZERO;
      end
    end else begin
      wb_ready_r <= 1'b1;
      for (int i = 0; i < NREG; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      if (wb_hit_s) begin
        regs_r[wb_addr] <= wb_data;
      end
    end
  end

  // Operand port 1; x0 is hardwired to zero and never busy.
  always_comb begin
    rs1_data = DATA_ZERO;
    rs1_busy = 1'b0;
    if (rs1_addr == ADDR_ZERO) begin
      rs1_data = DATA_ZERO;
      rs1_busy = 1'b0;
    end
`ifdef YSYX_24120013_RF_BYPASS_EN
    else if (wb_hit_s && (wb_addr == rs1_addr)) begin
      rs1_data = wb_data;
      rs1_busy = (cnt_nxt_s[rs1_addr] != CNT_ZERO);
    end
`endif
    else begin
      rs1_data = regs_r[rs1_addr];
      rs1_busy = (cnt_r[rs1_addr] != CNT_ZERO);
    end
  end

  // Operand port 2; identical behaviour to port 1.
  always_comb begin
    rs2_data = DATA_ZERO;
    rs2_busy = 1'b0;
    if (rs2_addr == ADDR_ZERO) begin
      rs2_data = DATA_ZERO;
      rs2_busy = 1'b0;
    end
`ifdef YSYX_24120013_RF_BYPASS_EN
    else if (wb_hit_s && (wb_addr == rs2_addr)) begin
      rs2_data = wb_data;
      rs2_busy = (cnt_nxt_s[rs2_addr] != CNT_ZERO);
    end
`endif
    else begin
      rs2_data = regs_r[rs2_addr];
      rs2_busy = (cnt_r[rs2_addr] != CNT_ZERO);
    end
  end

  // Any outstanding write anywhere in the file.
  always_comb begin
    pending_any = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      pending_any = pending_any | (cnt_r[i] != CNT_ZERO);
    end
  end

endmodule

// File: tb/tb_ysyx_24120013_regfile_sb.sv
// Self-checking bench for ysyx_24120013_regfile_sb: directed scenarios then random traffic
// against an array/count reference model (honours YSYX_24120013_RF_BYPASS_EN).
module tb_ysyx_24120013_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ready, iss_valid, iss_ready;
  logic [4:0]  wb_addr, iss_addr, rs1_addr, rs2_addr;
  logic [31:0] wb_data, rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy, pending_any;

  int          total = 0;
  int          passed = 0;

  int          m_cnt [32];
  int          m_nc  [32];
  logic [31:0] m_reg [32];
  logic        m_wbr;

  ysyx_24120013_regfile_sb dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
    .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = 0;
      m_reg[i] = 32'h0;
    end
    m_wbr = 1'b0;
  endtask

  task automatic idle();
    wb_valid = 1'b0; iss_valid = 1'b0;
    wb_addr = 5'd0; iss_addr = 5'd0; wb_data = 32'h0;
  endtask

  // Expected read for one port given this cycle's fire decisions.
  task automatic exp_read(input logic [4:0] a, input logic wbf,
                          output logic [31:0] d, output logic b);
    if (a == 5'd0) begin
      d = 32'h0; b = 1'b0;
    end else begin
      d = m_reg[a]; b = (m_cnt[a] != 0);
`ifdef YSYX_24120013_RF_BYPASS_EN
      if (wbf && wb_addr == a) begin
        d = wb_data; b = (m_nc[a] != 0);
      end
`endif
    end
  endtask

  // Check every output against the model, then advance one clock.
  task automatic step(input string tag);
    logic eir, wbf, isf, e1b, e2b, epa;
    logic [31:0] e1d, e2d;
    #1;
    eir = (iss_addr == 5'd0) || (m_cnt[iss_addr] < 3);
    wbf = wb_valid && m_wbr;
    isf = iss_valid && eir;
    epa = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_nc[i] = m_cnt[i];
      if (i != 0 && wbf && wb_addr == 5'(i) && m_nc[i] > 0) m_nc[i] = m_nc[i] - 1;
      if (i != 0 && isf && iss_addr == 5'(i)) m_nc[i] = m_nc[i] + 1;
      if (m_cnt[i] != 0) epa = 1'b1;
    end
    exp_read(rs1_addr, wbf, e1d, e1b);
    exp_read(rs2_addr, wbf, e2d, e2b);
    chk({tag, ".wb_ready"}, wb_ready, m_wbr);
    chk({tag, ".iss_ready"}, iss_ready, eir);
    chk({tag, ".rs1_data"}, rs1_data, e1d);
    chk({tag, ".rs1_busy"}, rs1_busy, e1b);
    chk({tag, ".rs2_data"}, rs2_data, e2d);
    chk({tag, ".rs2_busy"}, rs2_busy, e2b);
    chk({tag, ".pending_any"}, pending_any, epa);
    @(posedge clk);
    for (int i = 0; i < 32; i++) m_cnt[i] = m_nc[i];
    if (wbf && wb_addr != 5'd0) m_reg[wb_addr] = wb_data;
    m_wbr = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    model_reset();

    // Reset state
    #2;
    chk("rst.wb_ready", wb_ready, 32'h0);
    chk("rst.pending_any", pending_any, 32'h0);
    for (int a = 1; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(a);
      #1;
      chk("rst.rs1_data", rs1_data, 32'h0);
      chk("rst.rs2_data", rs2_data, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release.wb_ready_before_edge", wb_ready, 32'h0);
    @(posedge clk);
    #1;
    chk("release.wb_ready_after_edge", wb_ready, 32'h1);
    m_wbr = 1'b1;

    // Issue x5, writeback two cycles later
    rs1_addr = 5'd5; rs2_addr = 5'd0;
    iss_valid = 1'b1; iss_addr = 5'd5;
    step("x5.issue");
    idle();
    #1;
    chk("x5.busy_between", rs1_busy, 32'h1);
    step("x5.gap");
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    step("x5.wb");
    idle();
    #1;
    chk("x5.data_after", rs1_data, 32'hDEADBEEF);
    chk("x5.busy_after", rs1_busy, 32'h0);
    chk("x5.pending_after", pending_any, 32'h0);

    // Fill x7 to the counter limit, then mix issue and writeback
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    for (int k = 0; k < 3; k++) begin
      iss_valid = 1'b1; iss_addr = 5'd7;
      step("x7.fill");
    end
    #1;
    chk("x7.full_iss_ready", iss_ready, 32'h0);
    step("x7.blocked");
    idle();
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    step("x7.wb_once");
    idle();
    iss_addr = 5'd7;
    #1;
    chk("x7.ready_after_wb", iss_ready, 32'h1);
    iss_valid = 1'b1; wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h78;
    step("x7.iss_wb_same");
    idle();
    iss_valid = 1'b1; iss_addr = 5'd7;
    step("x7.refill");
    iss_valid = 1'b1; wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h79;
    step("x7.full_iss_wb");
    idle();
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'(k);
      step("x7.drain");
    end
    idle();

    // x0 is ignored for writes and issues
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h12345678;
    iss_valid = 1'b1; iss_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    chk("x0.iss_ready", iss_ready, 32'h1);
    step("x0.write_issue");
    idle();
    #1;
    chk("x0.rs2_data", rs2_data, 32'h0);
    chk("x0.rs2_busy", rs2_busy, 32'h0);

    // Same-cycle writeback seen on both read ports
    iss_valid = 1'b1; iss_addr = 5'd9;
    step("x9.issue");
    idle();
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5A5A5;
    rs1_addr = 5'd9; rs2_addr = 5'd9;
    #1;
`ifdef YSYX_24120013_RF_BYPASS_EN
    chk("x9.byp_rs1_data", rs1_data, 32'hA5A5A5A5);
    chk("x9.byp_rs2_data", rs2_data, 32'hA5A5A5A5);
    chk("x9.byp_rs1_busy", rs1_busy, 32'h0);
    chk("x9.byp_rs2_busy", rs2_busy, 32'h0);
`else
    chk("x9.nobyp_rs1_data", rs1_data, 32'h0);
    chk("x9.nobyp_rs2_data", rs2_data, 32'h0);
    chk("x9.nobyp_rs1_busy", rs1_busy, 32'h1);
    chk("x9.nobyp_rs2_busy", rs2_busy, 32'h1);
`endif
    step("x9.wb");
    idle();

    // Random traffic on a small address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      wb_valid  = ($urandom_range(0, 99) < 45);
      iss_valid = ($urandom_range(0, 99) < 45);
      wb_addr   = 5'($urandom_range(0, 7));
      iss_addr  = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      rs1_addr  = 5'($urandom_range(0, 7));
      rs2_addr  = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 7));
      if (iss_valid && wb_valid && iss_addr == wb_addr && m_cnt[wb_addr] == 0) wb_valid = 1'b0;
      step("rand");
    end
    idle();

    // Reset in the middle of traffic with x3 outstanding twice
    rs1_addr = 5'd3; rs2_addr = 5'd5;
    for (int k = 0; k < 2; k++) begin
      iss_valid = (m_cnt[3] < 3); iss_addr = 5'd3;
      step("x3.issue");
    end
    idle();
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33333333;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("midrst.rs1_data", rs1_data, 32'h0);
    chk("midrst.rs1_busy", rs1_busy, 32'h0);
    chk("midrst.rs2_data", rs2_data, 32'h0);
    chk("midrst.pending_any", pending_any, 32'h0);
    chk("midrst.wb_ready", wb_ready, 32'h0);
    @(posedge clk);
    #1;
    chk("midrst.x3_not_written", rs1_data, 32'h0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_wbr = 1'b1;
    step("post_rst.read");
    iss_valid = 1'b1; iss_addr = 5'd3;
    step("post_rst.issue");
    idle();
    step("post_rst.busy");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
